// File: rtl/phys_regfile.sv
// phys_regfile: physical register file with ready bits, write bypass and a registered ready count.
// Register 0 reads as constant 0/ready. Out-of-range indices read 0/not-ready and are ignored on update.
module phys_regfile #(
  parameter int XLEN      = 32,
  parameter int NUM_PREGS = 64,
  parameter int IDX_W     = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd1_idx,
  input  logic [IDX_W-1:0] rd2_idx,
  output logic [XLEN-1:0]  rd1_data,
  output logic [XLEN-1:0]  rd2_data,
  output logic             rd1_ready,
  output logic             rd2_ready,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [XLEN-1:0]  wr_data,
  input  logic             alloc_en,
  input  logic [IDX_W-1:0] alloc_idx,
  output logic [IDX_W:0]   num_ready
);
  localparam logic [IDX_W:0] NP = (IDX_W+1)'(NUM_PREGS);
  logic [XLEN-1:0]      mem [NUM_PREGS];
  logic [NUM_PREGS-1:0] rdy, rdy_n;
  logic [IDX_W:0]       cnt;
  logic                 v1, v2, wr_ok, al_ok, byp1, byp2;
  assign v1    = {1'b0, rd1_idx} < NP;
  assign v2    = {1'b0, rd2_idx} < NP;
  assign wr_ok = wr_en && !reset && wr_idx != '0 && {1'b0, wr_idx} < NP;
  assign al_ok = alloc_en && !reset && alloc_idx != '0 && {1'b0, alloc_idx} < NP;
  // Bypass is masked during reset so reads see the cleared state immediately.
  assign byp1  = wr_ok && wr_idx == rd1_idx;
  assign byp2  = wr_ok && wr_idx == rd2_idx;
  assign rd1_data  = !v1 ? '0 : byp1 ? wr_data : mem[rd1_idx];
  assign rd2_data  = !v2 ? '0 : byp2 ? wr_data : mem[rd2_idx];
  assign rd1_ready = v1 && (byp1 || rdy[rd1_idx]);
  assign rd2_ready = v2 && (byp2 || rdy[rd2_idx]);
  // Allocation is applied after the write so it wins on a same-index collision.
  always_comb begin
    rdy_n = rdy;
    if (wr_ok) rdy_n[wr_idx] = 1'b1;
    if (al_ok) rdy_n[alloc_idx] = 1'b0;
    cnt = '0;
    for (int i = 0; i < NUM_PREGS; i++) cnt += (IDX_W+1)'(rdy_n[i]);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) mem[i] <= '0;
      rdy       <= '1;
      num_ready <= NP;
    end else begin
      if (wr_ok) mem[wr_idx] <= wr_data;
      rdy       <= rdy_n;
      num_ready <= cnt;
    end
  end
endmodule

// File: tb/tb_phys_regfile.sv
// tb_phys_regfile: directed checks of reads, bypass, alloc/write interplay, num_ready and async reset.
module tb_phys_regfile;
  logic        clock = 0;
  logic        reset = 1;
  logic [5:0]  rd1_idx = 0, rd2_idx = 0, wr_idx = 0, alloc_idx = 0;
  logic [31:0] rd1_data, rd2_data, wr_data = 0;
  logic        rd1_ready, rd2_ready, wr_en = 0, alloc_en = 0;
  logic [6:0]  num_ready;
  int          n_run = 0, n_fail = 0;
  phys_regfile dut (
    .clock(clock), .reset(reset), .rd1_idx(rd1_idx), .rd2_idx(rd2_idx),
    .rd1_data(rd1_data), .rd2_data(rd2_data), .rd1_ready(rd1_ready), .rd2_ready(rd2_ready),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_idx(alloc_idx), .num_ready(num_ready)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic idle;
    wr_en = 0;
    alloc_en = 0;
  endtask
  initial begin
    #8;
    rd1_idx = 5; rd2_idx = 63; #1;
    chk("rst_d5", rd1_data, 0);
    chk("rst_r5", rd1_ready, 1);
    chk("rst_d63", rd2_data, 0);
    chk("rst_r63", rd2_ready, 1);
    chk("rst_num", num_ready, 64);
    #3 reset = 0;
    tick;
    alloc_en = 1; alloc_idx = 7;
    tick; idle; rd1_idx = 7; #1;
    chk("alloc7_r", rd1_ready, 0);
    chk("alloc7_num", num_ready, 63);
    wr_en = 1; wr_idx = 7; wr_data = 32'hDEADBEEF; #1;
    chk("byp7_d", rd1_data, 32'hDEADBEEF);
    chk("byp7_r", rd1_ready, 1);
    tick; idle; #1;
    chk("wr7_num", num_ready, 64);
    chk("wr7_d", rd1_data, 32'hDEADBEEF);
    chk("wr7_r", rd1_ready, 1);
    wr_en = 1; wr_idx = 0; wr_data = 32'h1234; rd1_idx = 0; #1;
    chk("wr0_byp_d", rd1_data, 0);
    chk("wr0_byp_r", rd1_ready, 1);
    tick; idle; #1;
    chk("wr0_d", rd1_data, 0);
    chk("wr0_num", num_ready, 64);
    alloc_en = 1; alloc_idx = 9; wr_en = 1; wr_idx = 9; wr_data = 32'hA5; rd1_idx = 9; #1;
    chk("aw9_byp_d", rd1_data, 32'hA5);
    chk("aw9_byp_r", rd1_ready, 1);
    tick; idle; #1;
    chk("aw9_d", rd1_data, 32'hA5);
    chk("aw9_r", rd1_ready, 0);
    chk("aw9_num", num_ready, 63);
    rd1_idx = 12; rd2_idx = 12; wr_en = 1; wr_idx = 12; wr_data = 32'h55; #1;
    chk("dual_d1", rd1_data, 32'h55);
    chk("dual_d2", rd2_data, 32'h55);
    chk("dual_r1", rd1_ready, 1);
    chk("dual_r2", rd2_ready, 1);
    tick; idle; #1;
    chk("dual_num", num_ready, 63);
    alloc_en = 1; alloc_idx = 20; wr_en = 1; wr_idx = 9; wr_data = 32'h77;
    tick; idle; rd1_idx = 9; rd2_idx = 20; #1;
    chk("split_d9", rd1_data, 32'h77);
    chk("split_r9", rd1_ready, 1);
    chk("split_r20", rd2_ready, 0);
    chk("split_num", num_ready, 63);
    alloc_en = 1; alloc_idx = 20;
    tick; idle; #1;
    chk("realloc_r", rd2_ready, 0);
    chk("realloc_num", num_ready, 63);
    wr_en = 1; wr_idx = 9; wr_data = 32'h88;
    tick; idle; #1;
    chk("rewr_d", rd1_data, 32'h88);
    chk("rewr_r", rd1_ready, 1);
    chk("rewr_num", num_ready, 63);
    alloc_en = 1; alloc_idx = 3; tick;
    alloc_idx = 4; tick;
    alloc_idx = 5; tick; #1;
    chk("a345_num", num_ready, 60);
    alloc_idx = 6; wr_en = 1; wr_idx = 12; wr_data = 32'h99; rd1_idx = 12; rd2_idx = 3;
    #1 reset = 1; #1;
    chk("arst_d", rd1_data, 0);
    chk("arst_r1", rd1_ready, 1);
    chk("arst_r2", rd2_ready, 1);
    chk("arst_num", num_ready, 64);
    #1 reset = 0;
    tick; idle; rd2_idx = 6; #1;
    chk("post_d12", rd1_data, 32'h99);
    chk("post_r6", rd2_ready, 0);
    chk("post_num", num_ready, 63);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
